// File: rtl/registers.sv
// General-purpose register file: 2^ADDR_WIDTH x DATA_WIDTH, two combinational
// read ports, one synchronous write port, index 0 hardwired to zero.
module registers #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  regWrite,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_en;

  // Writes to index 0 are dropped so storage for r0 never leaves zero.
  assign wr_en = regWrite && (writeRegister != '0);

  always_comb begin
    // NOTE: every entry defaults to its current value first, so no path
    // through this block leaves regs_d unassigned and no latch is inferred.
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
    end else if (wr_en) begin
      regs_d[writeRegister] = writeData;
    end
  end

  // NOTE: the whole array is cleared on reset because software relies on a
  // known-zero file; this keeps the storage in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so all entries update together at the edge.
    for (int i = 0; i < DEPTH; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // Reads see only registered state: no bypass from the pending write.
  assign readData1 = (readRegister1 == '0) ? '0 : regs_q[readRegister1];
  assign readData2 = (readRegister2 == '0) ? '0 : regs_q[readRegister2];

endmodule

// File: tb/tb_registers.sv
// Scoreboard bench for the register file: stimulus queues expected read
// values, a monitor compares them whenever a probe is raised.
module tb_registers;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] readRegister1, readRegister2, writeRegister;
  logic [DW-1:0] writeData;
  logic          regWrite;
  logic [DW-1:0] readData1, readData2;

  registers #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .writeRegister(writeRegister), .writeData(writeData),
    .regWrite(regWrite),
    .readData1(readData1), .readData2(readData2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } exp_t;

  exp_t sb_q[$];
  logic probe_req = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: outputs are sampled only when the stimulus raises a probe.
  initial begin
    exp_t e;
    forever begin
      @(posedge probe_req);
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_rd1"}, readData1, e.exp1);
        check({e.name, "_rd2"}, readData2, e.exp2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic probe(input string name, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2,
                       input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    readRegister1 = a1;
    readRegister2 = a2;
    #1;
    e.name = name; e.exp1 = e1; e.exp2 = e2;
    sb_q.push_back(e);
    probe_req = 1'b1;
    #1;
    probe_req = 1'b0;
    #1;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    writeRegister = a;
    writeData     = d;
    regWrite      = 1'b1;
    tick();
    regWrite      = 1'b0;
  endtask

  task automatic sweep_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      probe(name, i[AW-1:0], 5'(31 - i), '0, '0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; regWrite = 1'b0;
    writeRegister = '0; writeData = '0;
    readRegister1 = '0; readRegister2 = '0;
    #2;

    // Before any reset, index 0 still reads zero.
    probe("pre_reset_r0", 5'd0, 5'd0, 32'h0, 32'h0);

    // Reset clear: two reset edges, then sweep every index.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    sweep_zero("reset_clear");

    // Write / read-back, including the top index.
    write_reg(5'd5, 32'hDEADBEEF);
    write_reg(5'd31, 32'h12345678);
    probe("wr_rb", 5'd5, 5'd31, 32'hDEADBEEF, 32'h12345678);
    probe("wr_rb_swap", 5'd31, 5'd5, 32'h12345678, 32'hDEADBEEF);
    probe("same_index", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);

    // r0 immutable.
    write_reg(5'd0, 32'hFFFFFFFF);
    probe("r0_immutable", 5'd0, 5'd0, 32'h0, 32'h0);

    // Write enable off for 3 edges.
    write_reg(5'd7, 32'hA5A5A5A5);
    writeRegister = 5'd7; writeData = 32'h5A5A5A5A; regWrite = 1'b0;
    tick(); tick(); tick();
    probe("we_off", 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF);

    // Only the values at the edge matter for the write port.
    writeRegister = 5'd12; writeData = 32'h11111111; regWrite = 1'b1;
    #1;
    writeRegister = 5'd13; writeData = 32'h76543210;
    tick();
    regWrite = 1'b0;
    probe("edge_value", 5'd13, 5'd12, 32'h76543210, 32'h0);

    // Same-cycle read/write: old value before the edge, new value after.
    write_reg(5'd3, 32'h00000011);
    writeRegister = 5'd3; writeData = 32'h00000022; regWrite = 1'b1;
    probe("no_bypass", 5'd3, 5'd7, 32'h00000011, 32'hA5A5A5A5);
    tick();
    regWrite = 1'b0;
    probe("after_edge", 5'd3, 5'd7, 32'h00000022, 32'hA5A5A5A5);

    // Reset priority over a simultaneous write.
    write_reg(5'd9, 32'h0000BEEF);
    probe("r9_set", 5'd9, 5'd31, 32'h0000BEEF, 32'h12345678);
    reset = 1'b1; writeRegister = 5'd9; writeData = 32'hCAFEF00D; regWrite = 1'b1;
    tick();
    reset = 1'b0; regWrite = 1'b0;
    sweep_zero("reset_prio");

    // First write after deassertion is a normal write.
    write_reg(5'd9, 32'hCAFEF00D);
    probe("post_reset_wr", 5'd9, 5'd1, 32'hCAFEF00D, 32'h0);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) #1;
    if (sb_q.size() != 0) check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
